// File: rtl/gpio_hex_scan_driver.sv
// Two-digit multiplexed seven-segment driver for an 8-bit output register port.
// Digit 1 shows data_in[7:4], digit 0 shows data_in[3:0], both as hex. The scan
// runs DRIVE0 -> GAP0 -> DRIVE1 -> GAP1, blanking every digit during the gaps
// to avoid ghosting. The input is latched only on entry to DRIVE0, so one frame
// never shows a mix of old and new data.
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous, active-high reset
//   data_in_i      value to display (same clock domain)
//   enable_i       1 = scan, 0 = display dark
//   digit_sel_o    digit enables, bit0 = digit 0, bit1 = digit 1
//   seg_o          segments {g,f,e,d,c,b,a}
//   frame_done_o   one-cycle pulse when a complete frame wraps to DRIVE0
//   shown_value_o  currently latched display value
module gpio_hex_scan_driver #(
  parameter int unsigned REFRESH_DIV      = 50000,
  parameter int unsigned GAP_CYCLES       = 4,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit          LZ_BLANK         = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_in_i,
  input  logic       enable_i,
  output logic [1:0] digit_sel_o,
  output logic [6:0] seg_o,
  output logic       frame_done_o,
  output logic [7:0] shown_value_o
);

  localparam int unsigned MaxCnt = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  // XOR masks that turn active-high values into the physical polarity.
  localparam logic [6:0] SegOff = {7{SEG_ACTIVE_LOW}};
  localparam logic [1:0] DigOff = {2{DIGIT_ACTIVE_LOW}};

  typedef enum logic [2:0] {StIdle, StDrive0, StGap0, StDrive1, StGap1} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        shadow_q, shadow_d;
  logic [1:0]        digit_sel_q, digit_sel_d;
  logic [6:0]        seg_q, seg_d;
  logic              frame_done_q, frame_done_d;
  logic [1:0]        sel_raw;
  logic [6:0]        seg_raw;
  logic              drive_done, gap_done;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign drive_done = (cnt_q == CntW'(REFRESH_DIV - 1));
  assign gap_done   = (cnt_q == CntW'(GAP_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      // Dropping enable wins over every other transition, including capture.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StDrive0;
        StDrive0: if (drive_done) state_d = StGap0;
        StGap0:   if (gap_done)   state_d = StDrive1;
        StDrive1: if (drive_done) state_d = StGap1;
        StGap1:   if (gap_done)   state_d = StDrive0;
        default:  state_d = StIdle;
      endcase
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CntW'(1);

    shadow_d = shadow_q;
    if (state_d == StDrive0 && state_q != StDrive0) shadow_d = data_in_i;

    frame_done_d = (state_q == StGap1) && (state_d == StDrive0);

    // Outputs are decoded from the next state so they register on the same
    // edge as the state, and DRIVE0 shows the value captured on that edge.
    sel_raw = 2'b00;
    seg_raw = 7'h00;
    case (state_d)
      StDrive0: begin
        sel_raw = 2'b01;
        seg_raw = hex7(shadow_d[3:0]);
      end
      StDrive1: begin
        sel_raw = 2'b10;
        if (!(LZ_BLANK && shadow_d[7:4] == 4'h0)) seg_raw = hex7(shadow_d[7:4]);
      end
      default: ;
    endcase
    digit_sel_d = sel_raw ^ DigOff;
    seg_d       = seg_raw ^ SegOff;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shadow_q     <= 8'h00;
      digit_sel_q  <= DigOff;
      seg_q        <= SegOff;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      digit_sel_q  <= digit_sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_sel_o   = digit_sel_q;
  assign seg_o         = seg_q;
  assign frame_done_o  = frame_done_q;
  assign shown_value_o = shadow_q;

endmodule

// File: doc/gpio_hex_scan_driver.md
Name: gpio_hex_scan_driver

Overview:
Consumes the 8-bit parallel output port of the system's memory-mapped output register and drives a two-digit multiplexed seven-segment display. The high nibble goes to digit 1 and the low nibble to digit 0, both in hex. A time-multiplexed scan alternates between the digits, with a blanking gap between them to prevent ghosting. The input value is sampled only at frame boundaries, so a displayed frame never mixes old and new data.

Parameters:
REFRESH_DIV, 50000, clocks each digit is driven per frame (min 1)
GAP_CYCLES, 4, clocks with all digits off between digits (min 1)
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0)
DIGIT_ACTIVE_LOW, 1, 1 = digit selects inverted (selected = 0)
LZ_BLANK, 0, 1 = suppress digit 1 when the high nibble is 0

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
data_in  in  8  value from the output register port; not synchronised (same clock domain)
enable  in  1  1 = scan, 0 = display dark
digit_sel  out  2  digit enables; bit0 = digit 0, bit1 = digit 1; polarity per DIGIT_ACTIVE_LOW
seg  out  7  segments {g,f,e,d,c,b,a}; polarity per SEG_ACTIVE_LOW
frame_done  out  1  single-cycle pulse at the end of each complete frame
shown_value  out  8  currently latched display value (debug/readback)

Behaviour:
- Reset (async, active-high):
  - state = IDLE; prescaler = 0; shadow = 0.
  - digit_sel = all inactive; seg = all off; frame_done = 0; shown_value = 0.
  - Outputs reflect reset immediately; leaving reset is synchronous to clk.
- All outputs are registered. They change on the same clk edge as the state register.
- States: IDLE, DRIVE0, GAP0, DRIVE1, GAP1.
- Prescaler:
  - Counter width = clog2(max(REFRESH_DIV, GAP_CYCLES)).
  - Cleared on every state change; otherwise increments.
  - DRIVEx exits when the count reaches REFRESH_DIV-1, so each DRIVEx lasts exactly REFRESH_DIV cycles.
  - GAPx exits when the count reaches GAP_CYCLES-1, so each GAPx lasts exactly GAP_CYCLES cycles.
- Transitions:
  - IDLE -> DRIVE0 when enable=1.
  - DRIVE0 -> GAP0 -> DRIVE1 -> GAP1 -> DRIVE0 (cyclic).
  - Any state -> IDLE on the first edge where enable=0; the prescaler clears.
- Capture:
  - shadow <= data_in on every edge that enters DRIVE0, whether from IDLE or from GAP1.
  - shadow never changes elsewhere; shown_value = shadow.
- Outputs per state:
  - IDLE, GAP0, GAP1: digit_sel inactive, seg off.
  - DRIVE0: digit 0 selected, seg = hex(shadow[3:0]).
  - DRIVE1: digit 1 selected, seg = hex(shadow[7:4]).
  - In DRIVE0 the decode uses the value captured on that same edge.
- Leading-zero blanking: if LZ_BLANK=1 and shadow[7:4]=0, DRIVE1 keeps digit 1 selected but drives seg off. Timing is unchanged.
- Hex decode (active-high, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - SEG_ACTIVE_LOW=1 inverts all 7 bits.
- Digit exclusivity: at most one digit is ever selected. There is never an edge where both digits are active, including on enable toggles.
- frame_done:
  - Asserted for exactly 1 cycle, on the edge GAP1 -> DRIVE0.
  - Not asserted on IDLE -> DRIVE0, nor when an aborted frame goes to IDLE.
- Frame length = 2*(REFRESH_DIV+GAP_CYCLES) clocks.
- Simultaneous events: if enable falls on the same edge that would capture, IDLE wins and shadow is not updated.
- data_in changes mid-frame have no visible effect until the next DRIVE0 entry.

Test Plan:
1. Reset sequencing (REFRESH_DIV=4, GAP_CYCLES=2, active-low polarities): assert reset mid-DRIVE1 -> same cycle digit_sel=2'b11, seg=7'h7F, shown_value=0; release, enable=1 -> DRIVE0 on the next edge.
2. Scan timing: data_in=8'h3A, enable=1 -> digit_sel 2'b10 for 4 clk with seg=~77, then 2'b11 for 2 clk, then 2'b01 for 4 clk with seg=~4F, then 2'b11 for 2 clk; frame_done pulses once at clk 12; period repeats every 12 clk.
3. Tear-free update: change data_in 8'h3A -> 8'hC5 during DRIVE1 -> the rest of that frame still shows 3 on digit 1; the next frame shows 5 then C; shown_value changes only on DRIVE0 entry.
4. Leading-zero blank: LZ_BLANK=1, data_in=8'h07 -> DRIVE1 has digit_sel=2'b01, seg=7'h7F; DRIVE0 seg=~07. With data_in=8'h17, DRIVE1 seg=~06.
5. Enable abort: drop enable during GAP0 -> next edge IDLE, digits off, no frame_done; re-raise with data_in=8'hFF -> capture FF, DRIVE0 seg=~71, first frame_done at 12 clk after entry.
6. Full decode sweep: step data_in 8'h00..8'hFF, one value per frame -> seg matches the table for both nibbles; digit_sel never 2'b00 at any sampled edge.
